// File: rtl/asip_ctrl_pkg.sv
// Shared types and defaults for the ASIP run controller.
package asip_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLEAR,
    RUN,
    DISPLAY,
    ERROR
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 1000000;
  localparam int WDOG_W              = 20;

endpackage

// File: rtl/asip_run_ctrl_if.sv
// Switch, processor-handshake and status bundle of the run controller.
interface asip_run_ctrl_if;
  logic       switch_start;
  logic [1:0] red_switches;
  logic [1:0] green_switches;
  logic [1:0] blue_switches;
  logic       gtype_switch;
  logic       cpu_done;
  logic       cpu_run;
  logic       cpu_clr;
  logic [1:0] cfg_red;
  logic [1:0] cfg_green;
  logic [1:0] cfg_blue;
  logic       cfg_gtype;
  logic       vga_sel;
  logic       busy;
  logic       err;
  logic [7:0] frame_count;

  modport slave (
    input  switch_start, red_switches, green_switches, blue_switches,
           gtype_switch, cpu_done,
    output cpu_run, cpu_clr, cfg_red, cfg_green, cfg_blue, cfg_gtype,
           vga_sel, busy, err, frame_count
  );

  modport master (
    output switch_start, red_switches, green_switches, blue_switches,
           gtype_switch, cpu_done,
    input  cpu_run, cpu_clr, cfg_red, cfg_green, cfg_blue, cfg_gtype,
           vga_sel, busy, err, frame_count
  );
endinterface

// File: rtl/start_debouncer.sv
// Two-flop synchronizer plus stability debouncer for the active-low start button.
module start_debouncer
  import asip_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_start,
  output logic level,
  output logic fall_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          fall_q;

  // Level flips only after the synced input disagreed on DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], switch_start};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level      = level_q;
  assign fall_pulse = fall_q;
endmodule

// File: rtl/asip_run_ctrl.sv
// Start/run/display sequencer for the vector processor with watchdog and frame counter.
module asip_run_ctrl
  import asip_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  asip_run_ctrl_if.slave bus
);
  logic              start_level;
  logic              start_pulse;
  state_t            state_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              run_q, clr_q, vga_q, busy_q, err_q;
  logic [7:0]        frame_q;
  logic [1:0]        red_q, green_q, blue_q;
  logic              gtype_q;

  start_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk          (clk),
    .rst          (rst),
    .switch_start (bus.switch_start),
    .level        (start_level),
    .fall_pulse   (start_pulse)
  );

  // Outputs are assigned on the transition into the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      vga_q   <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      gtype_q <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        IDLE, ERROR: if (start_pulse) begin
          state_q <= LATCH;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
        LATCH: begin
          red_q   <= bus.red_switches;
          green_q <= bus.green_switches;
          blue_q  <= bus.blue_switches;
          gtype_q <= bus.gtype_switch;
          clr_q   <= 1'b1;
          vga_q   <= 1'b0;
          state_q <= CLEAR;
        end
        CLEAR: begin
          wdog_q  <= '0;
          run_q   <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          // Completion takes priority over a coincident watchdog expiry.
          if (bus.cpu_done) begin
            state_q <= DISPLAY;
            run_q   <= 1'b0;
            vga_q   <= 1'b1;
            busy_q  <= 1'b0;
            frame_q <= frame_q + 8'd1;
          end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ERROR;
            run_q   <= 1'b0;
            vga_q   <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        DISPLAY: if (start_level) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_run     = run_q;
  assign bus.cpu_clr     = clr_q;
  assign bus.vga_sel     = vga_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.frame_count = frame_q;
  assign bus.cfg_red     = red_q;
  assign bus.cfg_green   = green_q;
  assign bus.cfg_blue    = blue_q;
  assign bus.cfg_gtype   = gtype_q;
endmodule

// File: doc/asip_run_ctrl.md
ASIP_RUN_CTRL -- requirements
Module: asip_run_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles the synchronized start button shall be stable before its level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum RUN cycles before a watchdog error; the counter is 20 bits wide.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 switch_start  in  1  raw start button, active-low, asynchronous to clk.
REQ-006 red_switches, green_switches, blue_switches  in  2 each  raw colour-gain switches.
REQ-007 gtype_switch  in  1  raw filter-type select.
REQ-008 cpu_done  in  1  vector-processor program-complete pulse.
REQ-009 cpu_run  out  1  vector-processor execute enable.
REQ-010 cpu_clr  out  1  one-cycle processor PC/register clear pulse.
REQ-011 cfg_red, cfg_green, cfg_blue  out  2 each; cfg_gtype  out  1: latched configuration.
REQ-012 vga_sel  out  1  framebuffer owner: 1 = VGA reader, 0 = processor.
REQ-013 busy  out  1;  err  out  1;  frame_count  out  8.

Function
REQ-014 switch_start shall pass a 2-flop synchronizer and then the debouncer; a debounced high-to-low transition shall produce exactly one start_pulse cycle.
REQ-015 FSM states: IDLE, LATCH, CLEAR, RUN, DISPLAY, ERROR.
REQ-016 IDLE: vga_sel=1, cpu_run=0; start_pulse -> LATCH.
REQ-017 LATCH: capture all switches into cfg_* in this single cycle; -> CLEAR unconditionally.
REQ-018 CLEAR: cpu_clr=1 for exactly one cycle, vga_sel=0; clear the watchdog counter; -> RUN.
REQ-019 RUN: cpu_run=1, vga_sel=0, counter increments each cycle.
REQ-020 RUN exit: cpu_done=1 -> DISPLAY with frame_count+1; counter = TIMEOUT_CYCLES-1 with cpu_done=0 -> ERROR.
REQ-021 cpu_done and timeout in the same cycle: done wins, so the transition is to DISPLAY.
REQ-022 frame_count shall wrap from 255 to 0.
REQ-023 DISPLAY: vga_sel=1, cpu_run=0; remain until the debounced start level is high (released), then -> IDLE.
REQ-024 ERROR: err=1, vga_sel=1, cpu_run=0; start_pulse -> LATCH, and err clears on that transition.
REQ-025 busy=1 in LATCH, CLEAR and RUN; busy=0 otherwise.
REQ-026 start_pulse in LATCH, CLEAR, RUN or DISPLAY shall be ignored; cpu_done outside RUN shall be ignored.
REQ-027 Switch changes outside LATCH shall not alter cfg_*.
REQ-028 All outputs shall be registered; no combinational input-to-output path.

Reset
REQ-029 rst low shall immediately force: state IDLE, cpu_run=0, cpu_clr=0, vga_sel=1, busy=0, err=0, frame_count=0, cfg_*=0, counter=0, synchronizer and debounced level=1 (released).
REQ-030 Reset asserted mid-RUN shall drop cpu_run asynchronously; after release the FSM shall wait in IDLE for a new start_pulse.
REQ-031 Reset deassertion is synchronized externally; the block shall not synthesize its own reset synchronizer.

Structure
REQ-032 Package asip_ctrl_pkg shall hold the FSM state enum, the default DEBOUNCE_CYCLES/TIMEOUT_CYCLES and the counter width constant.
REQ-033 Synchronizer plus debounce shall be one sub-module, start_debouncer, with outputs level and fall_pulse.

Verification
REQ-034 Reset, then switch_start 1->0 held 10 cycles: exactly one start_pulse; LATCH->CLEAR->RUN on consecutive cycles; cpu_clr high one cycle.
REQ-035 Switches red=2, green=1, blue=3, gtype=1 at LATCH, changed to 0 during RUN: cfg_* remain 2/1/3/1.
REQ-036 cpu_done asserted 50 cycles into RUN: cpu_run low and vga_sel=1 next cycle; frame_count 0->1; FSM stays in DISPLAY until switch_start released, then IDLE.
REQ-037 TIMEOUT_CYCLES=16, no cpu_done: ERROR after 16 RUN cycles with err=1; a new start press clears err and re-enters LATCH.
REQ-038 cpu_done coincident with timeout: DISPLAY and err=0; 256 completed runs: frame_count wraps to 0.
REQ-039 Switch_start glitch shorter than DEBOUNCE_CYCLES: no start_pulse; rst low mid-RUN: all outputs reach reset values without a clock edge.
